// File: rtl/seq_div_pkg.sv
// seq_div_pkg -- shared constants and types for the sequential divider.
//   DIV_WIDTH   : default operand/result width
//   div_state_e : controller state encoding (RUN, FIX, DONE)
package seq_div_pkg;

  localparam int DIV_WIDTH = 8;

  // Reset always lands in RUN, so no idle state is needed.
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_FIX  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/seq_div_step.sv
// seq_div_step -- one combinational restoring-division step.
// The partial remainder is shifted left and the next dividend bit enters at
// the bottom. The divisor magnitude is then subtracted if it fits.
//   rem_i  : partial remainder before the step (WIDTH+1 bits)
//   bit_i  : next dividend bit, MSB first
//   dvs_i  : divisor magnitude (unsigned)
//   rem_o  : partial remainder after the step
//   qbit_o : quotient bit produced by this step
module seq_div_step
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic             qbit_o
);

  // Compare at WIDTH+2 bits so the shifted value can never overflow.
  // The remainder stays below the divisor, so truncating back to WIDTH+1
  // bits loses nothing.
  assign qbit_o = ({rem_i, bit_i} >= {2'b00, dvs_i});
  assign rem_o  = qbit_o ? (WIDTH+1)'({rem_i, bit_i} - {2'b00, dvs_i})
                         : (WIDTH+1)'({rem_i, bit_i});

endmodule

// File: rtl/seq_div.sv
// seq_div -- signed sequential restoring divider, one quotient bit per clock.
// A reset edge samples the operands and starts a division. rdy rises WIDTH+1
// edges later and stays high until the next reset.
//   clk   : clock, rising edge
//   reset : synchronous active-high reset and start strobe
//   a, b  : signed dividend / divisor, sampled on reset edges only
//   q, r  : signed quotient (truncated toward zero) and remainder (sign of a)
//   rdy   : results valid
//   dbz   : divide-by-zero flag, valid while rdy=1
module seq_div
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] q,
  output logic signed [WIDTH-1:0] r,
  output logic                    rdy,
  output logic                    dbz
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend bits out, quotient bits in
  logic [WIDTH-1:0] dvs_q;            // divisor magnitude
  logic [WIDTH-1:0] amag_q;           // dividend magnitude, kept for dbz result
  logic             sgn_quo_q, sgn_rem_q, zero_b_q;
  logic [WIDTH-1:0] q_q, q_d, r_q, r_d;
  logic             rdy_q, rdy_d, dbz_q, dbz_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   step_rem;
  logic             step_qbit;

  // |-2^(WIDTH-1)| wraps to 2^(WIDTH-1), which fits as an unsigned magnitude.
  assign a_mag = a[WIDTH-1] ? $unsigned(-a) : $unsigned(a);
  assign b_mag = b[WIDTH-1] ? $unsigned(-b) : $unsigned(b);

  seq_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .bit_i  (dvd_q[WIDTH-1]),
    .dvs_i  (dvs_q),
    .rem_o  (step_rem),
    .qbit_o (step_qbit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    q_d     = q_q;
    r_d     = r_q;
    rdy_d   = rdy_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_RUN: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[WIDTH-2:0], step_qbit};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (zero_b_q) begin
          // A zero divisor still runs the full step sequence, so the latency
          // is identical. The quotient bits it produced are discarded here.
          q_d   = '1;
          r_d   = sgn_rem_q ? (~amag_q + WIDTH'(1)) : amag_q;
          dbz_d = 1'b1;
        end else begin
          q_d = sgn_quo_q ? (~dvd_q + WIDTH'(1)) : dvd_q;
          r_d = sgn_rem_q ? (~rem_q[WIDTH-1:0] + WIDTH'(1)) : rem_q[WIDTH-1:0];
        end
        rdy_d   = 1'b1;
        state_d = ST_DONE;
      end
      default: ;  // DONE holds everything
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= a_mag;
      amag_q    <= a_mag;
      dvs_q     <= b_mag;
      sgn_quo_q <= a[WIDTH-1] ^ b[WIDTH-1];
      sgn_rem_q <= a[WIDTH-1];
      zero_b_q  <= (b == '0);
      q_q       <= '0;
      r_q       <= '0;
      rdy_q     <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      q_q     <= q_d;
      r_q     <= r_d;
      rdy_q   <= rdy_d;
      dbz_q   <= dbz_d;
    end
  end

  assign q   = q_q;
  assign r   = r_q;
  assign rdy = rdy_q;
  assign dbz = dbz_q;

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div -- scoreboard bench for seq_div (WIDTH=8).
// The driver starts divisions and queues the expected results.
// The monitor pops an entry whenever rdy rises and compares it with the DUT.
module tb_seq_div;

  typedef struct {
    logic signed [7:0] a;
    logic signed [7:0] b;
    logic signed [7:0] q;
    logic signed [7:0] r;
    logic              dbz;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic signed [7:0] a = '0;
  logic signed [7:0] b = '0;
  logic signed [7:0] q, r;
  logic              rdy, dbz;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   reset_cyc = 0;

  seq_div #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .q     (q),
    .r     (r),
    .rdy   (rdy),
    .dbz   (dbz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer division, truncated to 8 bits.
  function automatic exp_t model(input logic signed [7:0] av, input logic signed [7:0] bv);
    exp_t e;
    int   ai, bi;
    ai = av;
    bi = bv;
    e.a = av;
    e.b = bv;
    if (bi == 0) begin
      e.q   = -8'sd1;
      e.r   = av;
      e.dbz = 1'b1;
    end else begin
      e.q   = 8'(ai / bi);
      e.r   = 8'(ai % bi);
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Hold reset for nrst edges. Only the last edge carries the real operands.
  task automatic start(input logic signed [7:0] av, input logic signed [7:0] bv,
                       input bit push, input int nrst);
    for (int i = 0; i < nrst; i++) begin
      @(negedge clk);
      reset = 1'b1;
      a = (i == nrst - 1) ? av : 8'($urandom);
      b = (i == nrst - 1) ? bv : 8'($urandom);
    end
    if (push) sb.push_back(model(av, bv));
    @(negedge clk);
    reset = 1'b0;
    reset_cyc = cyc;
    check("reset_q", q, 0);
    check("reset_r", r, 0);
    check("reset_rdy", rdy, 0);
    check("reset_dbz", dbz, 0);
  endtask

  task automatic run_op(input logic signed [7:0] av, input logic signed [7:0] bv,
                        input int nrst);
    exp_t e;
    int   t;
    e = model(av, bv);
    start(av, bv, 1'b1, nrst);
    t = 0;
    while (sb.size() != 0 && t < 30) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: rdy never rose for a=%0d b=%0d", av, bv);
      sb.delete();
    end
    // DONE must ignore operand changes.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_rdy", rdy, 1);
      check("hold_q", q, e.q);
      check("hold_r", r, e.r);
      a = 8'($urandom);
      b = 8'($urandom);
    end
  endtask

  // Monitor: compare on each rising edge of rdy.
  initial begin
    logic rdy_prev;
    exp_t e;
    int   qi, ri, bi;
    rdy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rdy === 1'b1 && rdy_prev !== 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rdy: got rdy=1 expected no pending op");
        end else begin
          e = sb.pop_front();
          $display("op a=%0d b=%0d -> q=%0d r=%0d dbz=%0d (exp q=%0d r=%0d dbz=%0d)",
                   e.a, e.b, q, r, dbz, e.q, e.r, e.dbz);
          check("latency", cyc - reset_cyc, 9);
          check("q", q, e.q);
          check("r", r, e.r);
          check("dbz", dbz, e.dbz);
          if (e.dbz == 1'b0) begin
            qi = q;
            ri = r;
            bi = e.b;
            check("invariant_recon", 32'(8'(qi * bi + ri)), 32'(8'(e.a)));
            check("invariant_rmag", int'((ri < 0 ? -ri : ri) < (bi < 0 ? -bi : bi)), 1);
            check("invariant_rsign", int'(ri == 0 || ((ri < 0) == (e.a < 0))), 1);
          end
        end
      end
      rdy_prev = rdy;
    end
  end

  initial begin
    logic signed [7:0] ra, rb;
    run_op(8'sd100, 8'sd7, 1);
    run_op(-8'sd100, 8'sd7, 1);
    run_op(8'sd100, -8'sd7, 1);
    run_op(-8'sd100, -8'sd7, 1);
    run_op(8'sd5, 8'sd0, 1);
    run_op(-8'sd5, 8'sd0, 1);
    run_op(-8'sd128, -8'sd1, 1);
    run_op(-8'sd128, 8'sd1, 1);
    run_op(8'sd127, 8'sd127, 1);
    run_op(8'sd0, 8'sd3, 1);
    run_op(8'sd3, 8'sd100, 1);
    // Reset held over several edges: only the last sample counts.
    run_op(8'sd77, -8'sd9, 3);
    // Abandon a running division and restart with new operands.
    start(8'sd100, 8'sd7, 1'b0, 1);
    repeat (3) @(negedge clk);
    run_op(8'sd50, 8'sd6, 1);
    for (int n = 0; n < 500; n++) begin
      if (n % 50 == 0) begin
        ra = -8'sd128;
        rb = -8'sd1;
      end else begin
        ra = 8'($urandom);
        rb = 8'($urandom_range(1, 255));
      end
      run_op(ra, rb, 1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
